agc_gain_ctrl: RTL and testbench



---
 rtl/agc_gain_ctrl.sv | 150 +++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_ctrl.sv
// Automatic gain control: windowed peak detector driving the gain-stage code.
// Fast clip protection cuts gain as soon as a sample nears full scale.
module agc_gain_ctrl #(
   parameter int WINDOW     = 1024,
   parameter int HOLDOFF    = 256,
   parameter int HI_THRESH  = 24000,
   parameter int LO_THRESH  = 8000,
   parameter int CLIP_LEVEL = 32000,
   parameter int INIT_GAIN  = 8,
   parameter int MIN_GAIN   = 1,
   parameter int MAX_GAIN   = 63,
   parameter int STEP       = 1,
   parameter int CLIP_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        level_valid,
   input  logic [15:0] level_in,
   output logic [5:0]  gain_code,
   output logic        gain_update,
   output logic [15:0] peak_out,
   output logic        clip_event
);

   localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   // 8 bits so that MAX_GAIN + STEP cannot wrap before saturation
   localparam logic signed [7:0] MIN_S  = 8'(MIN_GAIN);
   localparam logic signed [7:0] MAX_S  = 8'(MAX_GAIN);
   localparam logic signed [7:0] STEP_S = 8'(STEP);
   localparam logic signed [7:0] CLIP_S = 8'(CLIP_STEP);

   typedef enum logic [1:0] {RUN, UPDATE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [15:0]       peak_q, peak_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [5:0]        gain_q, gain_d;
   logic [15:0]       pko_q, pko_d;
   logic              upd_q, upd_d;
   logic              clip_q, clip_d;

   logic [15:0]       pk_new;
   logic              is_clip;
   logic              win_end;
   logic signed [7:0] g_ext;
   logic signed [7:0] g_new;
   logic signed [7:0] g_sat;

   always_comb begin
      pk_new  = (level_in > peak_q) ? level_in : peak_q;
      is_clip = (level_in >= 16'(CLIP_LEVEL));
      win_end = (cnt_q == CW'(WINDOW - 1));
      g_ext   = $signed({2'b00, gain_q});
      if (is_clip)
         g_new = g_ext - CLIP_S;
      else if (pk_new > 16'(HI_THRESH))
         g_new = g_ext - STEP_S;
      else if (pk_new < 16'(LO_THRESH))
         g_new = g_ext + STEP_S;
      else
         g_new = g_ext;
      if (g_new < MIN_S)
         g_sat = MIN_S;
      else if (g_new > MAX_S)
         g_sat = MAX_S;
      else
         g_sat = g_new;
   end

   always_comb begin
      state_d = state_q;
      peak_d  = peak_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      gain_d  = gain_q;
      pko_d   = pko_q;
      upd_d   = 1'b0;
      clip_d  = 1'b0;
      if (!enable) begin
         state_d = RUN;
         peak_d  = '0;
         cnt_d   = '0;
         hold_d  = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (level_valid) begin
                  if (is_clip || win_end) begin
                     state_d = UPDATE;
                     peak_d  = '0;
                     cnt_d   = '0;
                     hold_d  = '0;
                     upd_d   = 1'b1;
                     gain_d  = g_sat[5:0];
                     clip_d  = is_clip;
                     pko_d   = is_clip ? level_in : pk_new;
                  end else begin
                     peak_d = pk_new;
                     cnt_d  = cnt_q + CW'(1);
                  end
               end
            end
            UPDATE: state_d = (HOLDOFF == 0) ? RUN : HOLD;
            HOLD: begin
               if (level_valid) begin
                  if (hold_q == HW'(HOLDOFF - 1)) begin
                     state_d = RUN;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         peak_q  <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         gain_q  <= 6'(INIT_GAIN);
         pko_q   <= '0;
         upd_q   <= 1'b0;
         clip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         peak_q  <= peak_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         gain_q  <= gain_d;
         pko_q   <= pko_d;
         upd_q   <= upd_d;
         clip_q  <= clip_d;
      end
   end

   assign gain_code   = gain_q;
   assign gain_update = upd_q;
   assign peak_out    = pko_q;
   assign clip_event  = clip_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Bench for agc_gain_ctrl with WINDOW=4, HOLDOFF=2.
// Table of windows plus hand sequences; updates checked against a queue.
module tb_agc_gain_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic        level_valid = 1'b0;
   logic [15:0] level_in = '0;
   logic [5:0]  gain_code;
   logic        gain_update;
   logic [15:0] peak_out;
   logic        clip_event;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [5:0]  gain;
      logic [15:0] peak;
      logic        clip;
   } exp_t;

   typedef struct {
      logic [15:0] s [4];
      int          dec;
      logic [5:0]  eg;
      logic [15:0] ep;
      logic        ec;
   } vec_t;

   exp_t q[$];

   agc_gain_ctrl #(.WINDOW(4), .HOLDOFF(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .level_valid(level_valid),
      .level_in(level_in),
      .gain_code(gain_code),
      .gain_update(gain_update),
      .peak_out(peak_out),
      .clip_event(clip_event)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (reset_n && (gain_update || clip_event)) begin
         if (q.size() == 0) begin
            checks++;
            $display("FAIL spurious_update: got upd=%0b clip=%0b expected none",
                     gain_update, clip_event);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("upd_cycle", cyc, e.cyc);
            check("upd_pulse", 32'(gain_update), 1);
            check("gain_code", 32'(gain_code), 32'(e.gain));
            check("peak_out", 32'(peak_out), 32'(e.peak));
            check("clip_event", 32'(clip_event), 32'(e.clip));
         end
      end
   end

   task automatic samp(input logic [15:0] s, input bit exp,
                       input logic [5:0] eg, input logic [15:0] ep,
                       input bit ec);
      level_valid = 1'b1;
      level_in = s;
      if (exp) q.push_back('{cyc: cyc + 1, gain: eg, peak: ep, clip: ec});
      @(negedge clk);
      level_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable = 1'b1;
      level_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain(input string nm);
      repeat (3) @(negedge clk);
      check(nm, q.size(), 0);
      q.delete();
   endtask

   vec_t vt [8];

   initial begin
      vt[0] = '{s: '{1000, 1000, 1000, 1000}, dec: 3, eg: 9, ep: 1000, ec: 0};
      vt[1] = '{s: '{5000, 30000, 2000, 100}, dec: 3, eg: 7, ep: 30000, ec: 0};
      vt[2] = '{s: '{5000, 32000, 0, 0}, dec: 1, eg: 4, ep: 32000, ec: 1};
      vt[3] = '{s: '{100, 200, 300, 32767}, dec: 3, eg: 4, ep: 32767, ec: 1};
      vt[4] = '{s: '{0, 0, 0, 0}, dec: 3, eg: 9, ep: 0, ec: 0};
      vt[5] = '{s: '{12000, 24000, 8000, 3}, dec: 3, eg: 8, ep: 24000, ec: 0};
      vt[6] = '{s: '{7999, 100, 200, 7999}, dec: 3, eg: 9, ep: 7999, ec: 0};
      vt[7] = '{s: '{24001, 0, 31999, 0}, dec: 3, eg: 7, ep: 31999, ec: 0};

      repeat (2) @(negedge clk);
      check("rst_gain", 32'(gain_code), 8);
      check("rst_peak", 32'(peak_out), 0);
      check("rst_upd", 32'(gain_update), 0);
      check("rst_clip", 32'(clip_event), 0);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         for (int i = 0; i < 4; i++)
            samp(vt[v].s[i], i == vt[v].dec, vt[v].eg, vt[v].ep, vt[v].ec);
         drain($sformatf("vec%0d_pending", v));
      end

      // clip mid-window, holdoff, then a clean restarted window
      do_reset();
      samp(5000, 0, 0, 0, 0);
      samp(32000, 1, 4, 32000, 1);
      samp(0, 0, 0, 0, 0);
      samp(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) samp(1000, 0, 0, 0, 0);
      samp(1000, 1, 5, 1000, 0);
      drain("restart_pending");

      // walk down to MIN_GAIN
      do_reset();
      samp(32000, 1, 4, 32000, 1);
      samp(0, 0, 0, 0, 0);
      samp(0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) samp(30000, 0, 0, 0, 0);
         samp(30000, 1, 6'(3 - k), 30000, 0);
         samp(0, 0, 0, 0, 0);
         samp(0, 0, 0, 0, 0);
      end
      samp(32100, 1, 1, 32100, 1);
      drain("min_pending");

      // walk up to MAX_GAIN and one more quiet window
      do_reset();
      for (int k = 1; k <= 56; k++) begin
         for (int i = 0; i < 3; i++) samp(0, 0, 0, 0, 0);
         samp(0, 1, (8 + k > 63) ? 6'd63 : 6'(8 + k), 0, 0);
         samp(0, 0, 0, 0, 0);
         samp(0, 0, 0, 0, 0);
      end
      drain("max_pending");

      // enable drop mid-window, clip sample ignored while disabled
      do_reset();
      for (int i = 0; i < 3; i++) samp(12000, 0, 0, 0, 0);
      enable = 1'b0;
      level_valid = 1'b1;
      level_in = 16'd32000;
      @(negedge clk);
      level_valid = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) samp(12000, 0, 0, 0, 0);
      samp(12000, 1, 8, 12000, 0);
      samp(0, 0, 0, 0, 0);
      samp(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) samp(1000, 0, 0, 0, 0);
      samp(1000, 1, 9, 1000, 0);
      samp(0, 0, 0, 0, 0);
      samp(0, 0, 0, 0, 0);
      samp(500, 0, 0, 0, 0);
      samp(500, 0, 0, 0, 0);
      drain("enable_pending");

      // async reset between edges
      #2 reset_n = 1'b0;
      #1;
      check("async_gain", 32'(gain_code), 8);
      check("async_peak", 32'(peak_out), 0);
      check("async_upd", 32'(gain_update), 0);
      check("async_clip", 32'(clip_event), 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) samp(20000, 0, 0, 0, 0);
      samp(20000, 1, 8, 20000, 0);
      drain("post_rst_pending");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
